// File: rtl/bus_arbiter4.sv
// ============================================================================
// Module   : bus_arbiter4
// Brief    : Four-way round-robin bus arbiter with 32-bit output mux and
//            ack watchdog.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter4 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic        ack,
    output logic [31:0] o,
    output logic [1:0]  sel,
    output logic [3:0]  grant,
    output logic        bus_req,
    output logic        timeout_err,
    output logic [1:0]  err_id
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_last;
    logic [1:0]       w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_bus_req_nxt;
    logic             w_terr_nxt;
    logic [1:0]       w_err_id_nxt;
    logic             w_found;
    logic [1:0]       w_winner;

    // Search starts just after the last owner so it gets lowest priority.
    always_comb begin
        logic [1:0] idx;
        w_found  = 1'b0;
        w_winner = r_last;
        idx      = r_last;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = grant;
        w_sel_nxt     = sel;
        w_bus_req_nxt = bus_req;
        w_terr_nxt    = 1'b0;
        w_err_id_nxt  = err_id;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = S_BUSY;
                    w_sel_nxt     = w_winner;
                    w_grant_nxt   = 4'b0001 << w_winner;
                    w_bus_req_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end
            end
            S_BUSY: begin
                // ack takes precedence over a coincident watchdog expiry.
                if (ack || (r_cnt == c_TERM)) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = 4'b0000;
                    w_bus_req_nxt = 1'b0;
                    w_last_nxt    = sel;
                    w_cnt_nxt     = '0;
                    if (!ack) begin
                        w_terr_nxt   = 1'b1;
                        w_err_id_nxt = sel;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 2'd3;
            r_cnt       <= '0;
            grant       <= 4'b0000;
            sel         <= 2'd0;
            bus_req     <= 1'b0;
            timeout_err <= 1'b0;
            err_id      <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            grant       <= w_grant_nxt;
            sel         <= w_sel_nxt;
            bus_req     <= w_bus_req_nxt;
            timeout_err <= w_terr_nxt;
            err_id      <= w_err_id_nxt;
        end
    end

    always_comb begin
        case (sel)
            2'd0:    o = x0;
            2'd1:    o = x1;
            2'd2:    o = x2;
            default: o = x3;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
// ============================================================================
// Module   : tb_bus_arbiter4
// Brief    : Directed vector bench for bus_arbiter4.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter4;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic [31:0] o;
    logic [1:0]  sel;
    logic [3:0]  grant;
    logic        bus_req;
    logic        timeout_err;
    logic [1:0]  err_id;

    logic [31:0] xv [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       bus_req;
        logic       terr;
        logic [1:0] err_id;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    bus_arbiter4 #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .x0          (xv[0]),
        .x1          (xv[1]),
        .x2          (xv[2]),
        .x3          (xv[3]),
        .ack         (ack),
        .o           (o),
        .sel         (sel),
        .grant       (grant),
        .bus_req     (bus_req),
        .timeout_err (timeout_err),
        .err_id      (err_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic a,
                       input logic [3:0] g, input logic [1:0] s, input logic b,
                       input logic t, input logic [1:0] e);
        vec_t v;
        v.rst = r; v.req = q; v.ack = a; v.grant = g; v.sel = s;
        v.bus_req = b; v.terr = t; v.err_id = e;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_cycles;
        logic released;
        logic terr_at_release;

        xv[0] = 32'hA0A0_0000;
        xv[1] = 32'hB1B1_1111;
        xv[2] = 32'hC2C2_2222;
        xv[3] = 32'hD3D3_3333;

        //  rst req     ack  grant    sel  breq terr eid
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);   // reset
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0);   // single request
        add(0, 4'b1110, 0, 4'b0001, 0, 1, 0, 0);   // req change ignored
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);   // ack releases
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);   // ack ignored in idle
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);   // reset before rotation
        add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 1, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b0100, 2, 1, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 2, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 3, 1, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 3, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 0, 1, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 0);   // owner 2 granted
        add(0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0);   // owner drops req
        add(0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0);
        add(0, 4'b0000, 0, 4'b0100, 2, 1, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 2, 0, 0, 0);
        add(0, 4'b1000, 0, 4'b1000, 3, 1, 0, 0);   // owner 3 granted
        add(1, 4'b1000, 0, 4'b0000, 0, 0, 0, 0);   // reset aborts
        add(0, 4'b1001, 0, 4'b0001, 0, 1, 0, 0);   // 0 wins after reset
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);

        rst = 1'b1; req = 4'b0000; ack = 1'b0;
        tick();
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; ack = vecs[i].ack;
            tick();
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("v%0d sel", i), 32'(sel), 32'(vecs[i].sel));
            chk($sformatf("v%0d bus_req", i), 32'(bus_req), 32'(vecs[i].bus_req));
            chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].terr));
            chk($sformatf("v%0d err_id", i), 32'(err_id), 32'(vecs[i].err_id));
            chk($sformatf("v%0d o", i), o, xv[vecs[i].sel]);
        end

        // Watchdog: requester 2 never acked (last owner is 0).
        rst = 1'b0; req = 4'b0100; ack = 1'b0;
        tick();
        req = 4'b0000;
        hi_cycles = 0;
        released = 1'b0;
        terr_at_release = 1'b0;
        for (int c = 0; c < 40 && !released; c++) begin
            if (grant == 4'b0100) begin
                hi_cycles++;
                chk("timeout early pulse", 32'(timeout_err), 32'd0);
                tick();
            end else begin
                released = 1'b1;
                terr_at_release = timeout_err;
            end
        end
        chk("timeout grant cycles", 32'(hi_cycles), 32'(TIMEOUT));
        chk("timeout pulse", 32'(terr_at_release), 32'd1);
        chk("timeout err_id", 32'(err_id), 32'd2);
        chk("timeout bus_req", 32'(bus_req), 32'd0);
        req = 4'b1011;
        tick();
        chk("post-timeout pulse cleared", 32'(timeout_err), 32'd0);
        chk("post-timeout winner", 32'(grant), 32'b1000);
        ack = 1'b1;
        tick();
        chk("post-timeout release", 32'(grant), 32'd0);

        // Ack coincident with counter == TIMEOUT-1 (last owner is 3).
        req = 4'b0010; ack = 1'b0;
        tick();
        chk("coincide grant", 32'(grant), 32'b0010);
        req = 4'b0000;
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            tick();
            chk($sformatf("coincide hold %0d", c), 32'(grant), 32'b0010);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("coincide release", 32'(grant), 32'd0);
        chk("coincide no pulse", 32'(timeout_err), 32'd0);
        chk("coincide err_id kept", 32'(err_id), 32'd2);
        tick();
        chk("coincide still no pulse", 32'(timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Round-robin arbiter that shares one 32-bit bus among four requesters.
- Grants exactly one requester per transaction, drives the 2-bit select of a 4:1 32-bit output mux, and holds ownership until the slave acknowledges.
- A watchdog recovers the bus if the slave never acknowledges.
- Sits between the CPU, VGA, DMA and debug masters and the shared memory/peripheral bus.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for ack before forced release (legal range 2..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i belongs to requester i.
- x0  input  32  bus word of requester 0 (address/data, packed by requester).
- x1  input  32  bus word of requester 1.
- x2  input  32  bus word of requester 2.
- x3  input  32  bus word of requester 3.
- ack  input  1  slave completion strobe; one cycle.
- o  output  32  muxed bus word = x[sel], combinational.
- sel  output  2  registered index of current/last owner.
- grant  output  4  registered one-hot grant; all zero when idle.
- bus_req  output  1  registered; 1 while a transaction is in flight (BUSY).
- timeout_err  output  1  registered one-cycle pulse on watchdog expiry.
- err_id  output  2  index of the requester that timed out; holds until next timeout or reset.

Behaviour:
- Reset (rst=1 at clk edge):
  - grant=0, sel=0, bus_req=0, timeout_err=0, err_id=0, counter=0.
  - Internal last-owner pointer=3, so requester 0 has top priority first.
  - State=IDLE.
  - Reset mid-transaction aborts it immediately with no error pulse.
- o = x0/x1/x2/x3 per sel at all times. In IDLE, sel holds the last owner's index.
- States: IDLE, BUSY.
- IDLE:
  - If req!=0: winner = first set bit searching last+1, last+2, last+3, last (mod 4).
  - Next edge: sel=winner, grant=one-hot(winner), bus_req=1, counter=0, go BUSY.
  - Latency: req seen at edge N gives grant high after edge N.
  - ack is ignored in IDLE.
- BUSY:
  - Grant is locked; req changes (including the owner dropping req) are ignored.
  - Requesters must hold x* stable until grant falls.
  - ack=1: next edge grant=0, bus_req=0, last=sel, go IDLE.
  - No ack and counter==TIMEOUT-1: next edge grant=0, bus_req=0, timeout_err=1 for one cycle, err_id=sel, last=sel, go IDLE.
  - Otherwise: counter increments.
  - ack and expiry in the same cycle: ack wins, no error.
- One mandatory IDLE cycle between transactions. Back-to-back grants are therefore at best every other cycle plus the ack wait.
- Fairness: a requester holding req continuously is granted within 4 transactions. The last owner is lowest priority in the next arbitration.
- timeout_err is 0 in every cycle other than the single expiry pulse.
- Counter never wraps: it is cleared on entry to BUSY and bounded by TIMEOUT.

Test Plan:
- Reset then req=4'b0001, ack one cycle after grant → grant=0001 one cycle after req, sel=0, o=x0; grant=0000 after ack edge; bus_req pulses for 2 cycles.
- req=4'b1111 held, ack every BUSY cycle → grant sequence 0001,0010,0100,1000,0001; sel 0,1,2,3,0; one idle cycle between grants.
- Owner 2 granted, req2 dropped mid-BUSY, ack 3 cycles later → grant stays 0100 until ack; no early release.
- TIMEOUT=16, req=4'b0100, never ack → grant 0100 for exactly 16 cycles; timeout_err=1 for one cycle; err_id=2; next arbitration starts search at requester 3.
- Ack arriving in the same cycle the counter reaches 15 → clean release, timeout_err stays 0, err_id unchanged.
- rst asserted while BUSY with grant=1000 → next edge grant=0000, bus_req=0, sel=0; then req=4'b1001 grants requester 0 first.
